vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Generates 640x480@60 VGA raster timing for the pinball display: drives pixelX/pixelY to every drawing object, collects the composited 8-bit RGB they return, and emits aligned sync, blank and 8-bit-per-channel colour to the DAC pins. It sits at the other end of the object pixel interface: it is the producer of pixel coordinates and the final consumer of object RGB. Its internal pipeline delay compensates for the registered latency of the object/mux chain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- PIPE_DELAY, 1, clocks from pixelX/pixelY to valid RGBin; legal range 1..4
- BORDER_COLOR, 8'hFF, RGB332 colour of the optional frame border
- clk  in  1  pixel clock, 25 MHz, one pixel per cycle
- resetN  in  1  asynchronous active-low reset
- RGBin  in  8  composited RGB332 ({R[2:0],G[2:0],B[1:0]}) for the pixel issued PIPE_DELAY cycles earlier
- pixelX  out  11 signed  current horizontal count, 0..799
- pixelY  out  11 signed  current vertical count, 0..524
- startOfFrame  out  1  one-cycle pulse when pixelX==0 and pixelY==0
- hSync, vSync  out  1 each  active-low syncs, pipeline-aligned with the colour outputs
- blankN  out  1  high when the colour outputs carry a visible pixel
- red, green, blue  out  8 each  expanded colour, zero while blanked

## Operation
- hCount wraps 799 -> 0. On wrap, vCount increments and wraps 524 -> 0. pixelX/pixelY are the registered counters, driven through the blanking intervals as well.
- Visible region: hCount < H_ACTIVE and vCount < V_ACTIVE.
- hSync low for hCount in [656, 752). vSync low for vCount in [490, 492). Both are derived from the undelayed counters, then delayed.
- visible, hSync and vSync pass through a delay line of PIPE_DELAY stages. RGBin is sampled when the delayed visible flag is set.
- Colour expansion by bit replication:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - Example: 8'hE0 -> FF/00/00, 8'hFF -> FF/FF/FF.
- When the delayed visible flag is clear: red/green/blue = 0 and blankN = 0, regardless of RGBin.
- Transparent encoding 8'hFF is not special-cased; background fill is upstream's responsibility.
- Reset, including mid-frame: all of the following take effect immediately and asynchronously.
  - counters 0 and delay line cleared to "not visible, syncs inactive"
  - pixelX = pixelY = 0, startOfFrame = 0
  - hSync = vSync = 1, blankN = 0, red/green/blue = 0
  - On release the first clock starts frame 0 at (0,0).

## Timing
- Pixel (x,y) is presented on pixelX/pixelY in cycle t. RGBin for it must be valid in cycle t+PIPE_DELAY.
- The colour, blankN, hSync and vSync for that pixel appear registered in cycle t+PIPE_DELAY+1.
- startOfFrame is asserted in the same cycle pixelX/pixelY show (0,0). It is not delayed.
- Line period 800 clocks; frame period 420000 clocks.
- The first startOfFrame after reset release is in cycle 0, and the next one is in cycle 420000.

## Configuration
- VGA_BORDER_EN defined: a visible pixel with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 outputs the expansion of BORDER_COLOR, ignoring RGBin. Alignment is identical to normal pixels.
- VGA_BORDER_EN undefined: no border logic; all visible pixels come from RGBin.

## Structure
- Package vga_pkg holds:
  - the default timing constants
  - the rgb332_t typedef
  - the rgb332-to-24-bit expand function
  - the derived H_TOTAL/V_TOTAL and sync-start constants
- Sub-module vga_delay_line: a parameterised-width, parameterised-depth shift register with asynchronous active-low clear to a parameter value. It is used for the visible/sync delay.

## Test plan
- Reset asserted mid-line at hCount=300 -> all outputs return to reset values that same cycle. After release, pixelX = 0,1,2… with startOfFrame high in the first cycle.
- Run 801 clocks -> pixelX wraps 799 -> 0 and pixelY steps 0 -> 1 on the same edge.
- Line 0 -> hSync low for exactly 96 cycles, first low cycle 656+PIPE_DELAY+1 after the pixelX==0 cycle. vSync low for exactly 1600 cycles starting at line 490.
- Drive RGBin=8'hE0 PIPE_DELAY cycles after pixel (0,0) with PIPE_DELAY=1 and 3 -> red=FF, green=00, blue=00, blankN=1 exactly PIPE_DELAY+1 cycles after (0,0).
- Hold RGBin=8'hFF through hCount 640..799 -> red/green/blue=0 and blankN=0 for those pixels.
- Build with VGA_BORDER_EN, BORDER_COLOR=8'h1C, RGBin=8'h00 -> pixels (0,5), (639,5), (5,0), (5,479) output green=FF, red=blue=00. Pixel (5,5) outputs all zero.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan controller.
//   - default 640x480@60 timing constants and derived totals / sync starts
//   - rgb332_t colour typedef ({R[2:0],G[2:0],B[1:0]})
//   - rgb332_expand(): RGB332 -> 24-bit {red,green,blue} by bit replication
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_HS_START   = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_VS_START   = VGA_V_ACTIVE + VGA_V_FP;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Replicating the MSBs makes full-scale codes map to 8'hFF and zero to 8'h00.
    function automatic logic [23:0] rgb332_expand(input rgb332_t c);
        return {c.r, c.r, c.r[2:1], c.g, c.g, c.g[2:1], c.b, c.b, c.b, c.b};
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// vga_scan_controller_if: object pixel interface plus DAC pins.
//   pixelX/pixelY/startOfFrame : coordinates issued to the drawing objects
//   RGBin                      : composited RGB332 returned by the object/mux chain
//   hSync/vSync/blankN/red/green/blue : aligned outputs to the VGA DAC
// modport master = scan controller, modport slave = object chain / DAC side.
interface vga_scan_controller_if;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               startOfFrame;
    logic [7:0]         RGBin;
    logic               hSync;
    logic               vSync;
    logic               blankN;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;

    modport master (
        output pixelX, pixelY, startOfFrame, hSync, vSync, blankN, red, green, blue,
        input  RGBin
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, hSync, vSync, blankN, red, green, blue,
        output RGBin
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH-bit shift register of DEPTH stages (DEPTH >= 1),
// asynchronously cleared to RESET_VAL by active-low rst_n.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   d_i   : input word
//   q_o   : input word delayed by DEPTH clocks
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA raster timing generator and final colour stage.
//   clk    : pixel clock, one pixel per cycle
//   resetN : asynchronous active-low reset
//   vga    : vga_scan_controller_if.master (pixel coordinates out, RGBin in,
//            aligned sync/blank/colour out)
// Optional feature macro: VGA_BORDER_EN forces the outermost visible rows and
// columns to BORDER_COLOR.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_FP         = VGA_H_FP,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_BP         = VGA_H_BP,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_FP         = VGA_V_FP,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_BP         = VGA_V_BP,
    parameter int unsigned PIPE_DELAY   = 1,
    parameter logic [7:0]  BORDER_COLOR = 8'hFF
) (
    input  logic                  clk,
    input  logic                  resetN,
    vga_scan_controller_if.master vga
);

    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Counters, frame-start flag and run flag.
    // The first clock after reset release only sets run_q, so the counters
    // present (0,0) with startOfFrame high for one full cycle (frame 0).
    logic        run_q;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        sof_q, sof_d;

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        sof_d = 1'b0;
        if (!run_q) begin
            h_d   = '0;
            v_d   = '0;
            sof_d = 1'b1;
        end else begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
            sof_d = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            run_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
            sof_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            h_q   <= h_d;
            v_q   <= v_d;
            sof_q <= sof_d;
        end
    end

    // Undelayed per-pixel flags; gated by run_q so the hold cycle after
    // reset release does not inject a duplicate (0,0) into the pipeline.
    logic vis_in, hs_in, vs_in;
    assign vis_in = run_q && (h_q < H_VIS) && (v_q < V_VIS);
    assign hs_in  = !(run_q && (h_q >= HS_START) && (h_q < HS_END));
    assign vs_in  = !(run_q && (v_q >= VS_START) && (v_q < VS_END));

`ifdef VGA_BORDER_EN
    localparam int unsigned PW = 4;
    logic border_in;
    assign border_in = (h_q == '0) || (h_q == H_VIS - 11'd1) ||
                       (v_q == '0) || (v_q == V_VIS - 11'd1);
    logic [PW-1:0] pipe_in, pipe_out;
    assign pipe_in = {border_in, vis_in, hs_in, vs_in};
`else
    localparam int unsigned PW = 3;
    logic [PW-1:0] pipe_in, pipe_out;
    assign pipe_in = {vis_in, hs_in, vs_in};
`endif

    // Reset word: not visible, both syncs inactive (high).
    vga_delay_line #(
        .WIDTH     (PW),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (PW'(3))
    ) u_delay (
        .clk   (clk),
        .rst_n (resetN),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    // Output register stage: RGBin is sampled on the edge where the delayed
    // visible flag belongs to the same pixel.
    logic        hs_q, vs_q, blank_q;
    logic [23:0] rgb_q;
    rgb332_t     src_col;

    always_comb begin
        src_col = rgb332_t'(vga.RGBin);
`ifdef VGA_BORDER_EN
        if (pipe_out[3]) src_col = rgb332_t'(BORDER_COLOR);
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hs_q    <= pipe_out[1];
            vs_q    <= pipe_out[0];
            blank_q <= pipe_out[2];
            rgb_q   <= pipe_out[2] ? rgb332_expand(src_col) : '0;
        end
    end

    assign vga.pixelX       = $signed(h_q);
    assign vga.pixelY       = $signed(v_q);
    assign vga.startOfFrame = sof_q;
    assign vga.hSync        = hs_q;
    assign vga.vSync        = vs_q;
    assign vga.blankN       = blank_q;
    assign vga.red          = rgb_q[23:16];
    assign vga.green        = rgb_q[15:8];
    assign vga.blue         = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: two controller instances (full 640x480 timing with
// PIPE_DELAY=1, and a shrunken raster with PIPE_DELAY=3) driven with random
// RGBin and compared every cycle against a raster model computed from the
// cycle index. Build with VGA_BORDER_EN for the border variant.
module tb_vga_scan_controller;

    localparam int A_D  = 1;
    localparam int B_HA = 16, B_HF = 2, B_HS = 4, B_HB = 3;
    localparam int B_VA = 12, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_D  = 3;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;   // 25
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;   // 19
    localparam int RUN  = 4800;

`ifdef VGA_BORDER_EN
    localparam logic [7:0] BCOL   = 8'h1C;
    localparam bit         BORDER = 1'b1;
`else
    localparam logic [7:0] BCOL   = 8'hFF;
    localparam bit         BORDER = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    vga_scan_controller_if ia ();
    vga_scan_controller_if ib ();

    vga_scan_controller #(
        .PIPE_DELAY   (A_D),
        .BORDER_COLOR (BCOL)
    ) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .vga    (ia)
    );

    vga_scan_controller #(
        .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .PIPE_DELAY   (B_D),
        .BORDER_COLOR (BCOL)
    ) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .vga    (ib)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] hist_a [0:RUN];
    logic [7:0] hist_b [0:RUN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raster model: position from cycle index, outputs from the pixel issued
    // d+1 cycles earlier, colour from RGBin held one cycle earlier.
    function automatic void model(input int n, input int d,
                                  input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input logic [7:0] rgbin,
                                  output logic [10:0] px, output logic [10:0] py,
                                  output logic sof, output logic hs, output logic vs,
                                  output logic bl, output logic [23:0] rgb);
        int ht, vt, p, x, y, r, g, b;
        logic [7:0] c;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        px  = 11'(n % ht);
        py  = 11'((n / ht) % vt);
        sof = (n % (ht * vt)) == 0;
        hs  = 1'b1; vs = 1'b1; bl = 1'b0; rgb = '0;
        p   = n - d - 1;
        if (p >= 0) begin
            x  = p % ht;
            y  = (p / ht) % vt;
            hs = !(x >= ha + hf && x < ha + hf + hsw);
            vs = !(y >= va + vf && y < va + vf + vsw);
            if (x < ha && y < va) begin
                bl = 1'b1;
                c  = rgbin;
                if (BORDER && (x == 0 || x == ha - 1 || y == 0 || y == va - 1)) c = BCOL;
                r = int'(c[7:5]); g = int'(c[4:2]); b = int'(c[1:0]);
                rgb = {8'(r * 36 + r / 2), 8'(g * 36 + g / 2), 8'(b * 85)};
            end
        end
    endfunction

    task automatic check_outputs(input string pfx, input bit is_b,
                                 input logic [10:0] px, input logic [10:0] py,
                                 input logic sof, input logic hs, input logic vs,
                                 input logic bl, input logic [23:0] rgb);
        if (!is_b) begin
            chk({pfx, ".pixelX"}, 32'($unsigned(ia.pixelX)), 32'(px));
            chk({pfx, ".pixelY"}, 32'($unsigned(ia.pixelY)), 32'(py));
            chk({pfx, ".sof"},    32'(ia.startOfFrame), 32'(sof));
            chk({pfx, ".hSync"},  32'(ia.hSync), 32'(hs));
            chk({pfx, ".vSync"},  32'(ia.vSync), 32'(vs));
            chk({pfx, ".blankN"}, 32'(ia.blankN), 32'(bl));
            chk({pfx, ".rgb"},    32'({ia.red, ia.green, ia.blue}), 32'(rgb));
        end else begin
            chk({pfx, ".pixelX"}, 32'($unsigned(ib.pixelX)), 32'(px));
            chk({pfx, ".pixelY"}, 32'($unsigned(ib.pixelY)), 32'(py));
            chk({pfx, ".sof"},    32'(ib.startOfFrame), 32'(sof));
            chk({pfx, ".hSync"},  32'(ib.hSync), 32'(hs));
            chk({pfx, ".vSync"},  32'(ib.vSync), 32'(vs));
            chk({pfx, ".blankN"}, 32'(ib.blankN), 32'(bl));
            chk({pfx, ".rgb"},    32'({ib.red, ib.green, ib.blue}), 32'(rgb));
        end
    endtask

    task automatic check_cycle(input int n);
        logic [10:0] px, py;
        logic sof, hs, vs, bl;
        logic [23:0] rgb;
        model(n, A_D, 640, 16, 96, 48, 480, 10, 2, 33,
              (n > 0) ? hist_a[n-1] : 8'h00, px, py, sof, hs, vs, bl, rgb);
        check_outputs("a", 1'b0, px, py, sof, hs, vs, bl, rgb);
        model(n, B_D, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB,
              (n > 0) ? hist_b[n-1] : 8'h00, px, py, sof, hs, vs, bl, rgb);
        check_outputs("b", 1'b1, px, py, sof, hs, vs, bl, rgb);
    endtask

    // RGBin for cycle n: random, with directed overrides.
    task automatic drive(input int n);
        int pa, pb;
        logic [7:0] va, vb;
        va = 8'($urandom);
        vb = 8'($urandom);
        pa = n - A_D;
        pb = n - B_D;
        if (pa == 0) va = 8'hE0;
        if (pb == 0) vb = 8'hE0;
        if (pa >= 0 && pa / 800 == 1 && pa % 800 >= 640) va = 8'hFF;
        if (BORDER && pa >= 0 && (pa / 800 == 0 || pa / 800 == 5)) va = 8'h00;
        if (BORDER && pb >= 0 && (pb / B_HT) % B_VT == B_VA - 1) vb = 8'h00;
        hist_a[n] = va;
        hist_b[n] = vb;
        ia.RGBin  = va;
        ib.RGBin  = vb;
    endtask

    int hs_low_cnt, hs_first, vs_low_cnt, vs_first;

    initial begin
        ia.RGBin = 8'h00;
        ib.RGBin = 8'h00;
        hs_low_cnt = 0; hs_first = -1;
        vs_low_cnt = 0; vs_first = -1;

        // Reset state
        #12;
        check_outputs("rst_a", 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
        check_outputs("rst_b", 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0);

        // Run to hCount=300, then assert reset mid-line
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n <= 300; n++) begin
            check_cycle(n);
            drive(n);
            if (n < 300) begin
                @(posedge clk); #1;
            end
        end
        chk("pre_reset_x300", 32'($unsigned(ia.pixelX)), 32'd300);
        #2 resetN = 1'b0;
        #1;
        check_outputs("midrst_a", 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
        check_outputs("midrst_b", 1'b1, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
        @(posedge clk);
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;

        // Main run from frame 0
        for (int n = 0; n < RUN; n++) begin
            check_cycle(n);
            if (n == 0) chk("sof_first", 32'(ia.startOfFrame), 32'd1);
            if (n == 799) chk("wrap_x799", 32'($unsigned(ia.pixelX)), 32'd799);
            if (n == 800) begin
                chk("wrap_x0", 32'($unsigned(ia.pixelX)), 32'd0);
                chk("wrap_y1", 32'($unsigned(ia.pixelY)), 32'd1);
            end
            if (n == A_D + 1) begin
                chk("a_e0_rgb", 32'({ia.red, ia.green, ia.blue}), 32'h00FF0000);
                chk("a_e0_blankN", 32'(ia.blankN), 32'd1);
            end
            if (n == B_D + 1) begin
                chk("b_e0_rgb", 32'({ib.red, ib.green, ib.blue}), 32'h00FF0000);
                chk("b_e0_blankN", 32'(ib.blankN), 32'd1);
            end
            if (n == 800 + 700 + A_D + 1) begin
                chk("a_hblank_rgb", 32'({ia.red, ia.green, ia.blue}), 32'h0);
                chk("a_hblank_blankN", 32'(ia.blankN), 32'd0);
            end
`ifdef VGA_BORDER_EN
            if (n == 5 * 800 + 0 + A_D + 1 || n == 5 * 800 + 639 + A_D + 1 || n == 5 + A_D + 1)
                chk("a_border", 32'({ia.red, ia.green, ia.blue}), 32'h0000FF00);
            if (n == 5 * 800 + 5 + A_D + 1)
                chk("a_inner", 32'({ia.red, ia.green, ia.blue}), 32'h0);
            if (n == (B_VA - 1) * B_HT + 5 + B_D + 1)
                chk("b_border_bottom", 32'({ib.red, ib.green, ib.blue}), 32'h0000FF00);
`endif
            if (n < 800 && ia.hSync == 1'b0) begin
                if (hs_first < 0) hs_first = n;
                hs_low_cnt++;
            end
            if (n < B_HT * B_VT && ib.vSync == 1'b0) begin
                if (vs_first < 0) vs_first = n;
                vs_low_cnt++;
            end
            drive(n);
            @(posedge clk); #1;
        end

        chk("a_hsync_len",   32'(hs_low_cnt), 32'd96);
        chk("a_hsync_first", 32'(hs_first),   32'(656 + A_D + 1));
        chk("b_vsync_len",   32'(vs_low_cnt), 32'(B_VS * B_HT));
        chk("b_vsync_first", 32'(vs_first),   32'((B_VA + B_VF) * B_HT + B_D + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
